// File: rtl/lock_arb_pkg.sv
// lock_arb_pkg: shared types and helpers for lock_rr_arbiter.
//   arb_state_e : arbiter FSM state (ARB_IDLE, ARB_BUSY)
//   idx_width() : width of a binary index covering n requesters (minimum 1)
package lock_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational masked priority picker.
//   request_i    : one bit per requester
//   ptr_i        : round-robin search start index (ignored in fixed mode)
//   mode_rr_i    : 0 = lowest index wins, 1 = search upward from ptr_i with wrap
//   winner_oh_o  : one-hot winner (all zero when request_i is zero)
//   winner_idx_o : binary winner index (zero when request_i is zero)
module rr_pick
  import lock_arb_pkg::*;
#(
  parameter  int unsigned REQ_NUM = 3,
  localparam int unsigned IW      = idx_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] request_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               mode_rr_i,
  output logic [REQ_NUM-1:0] winner_oh_o,
  output logic [IW-1:0]      winner_idx_o
);

  int unsigned base;
  int unsigned idx;
  logic        found;

  // Walk REQ_NUM positions starting at base; the subtract-on-overflow wrap
  // keeps non-power-of-two requester counts correct (ptr_i < REQ_NUM).
  always_comb begin
    winner_oh_o  = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    idx          = 0;
    base         = mode_rr_i ? 32'(ptr_i) : 0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      idx = base + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && request_i[idx]) begin
        found             = 1'b1;
        winner_oh_o[idx]  = 1'b1;
        winner_idx_o      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/lock_rr_arbiter.sv
// lock_rr_arbiter: locked-grant request arbiter, fixed or round-robin priority.
// A grant is held until the granted master pulses release_i; one idle cycle
// always separates consecutive grants.
//   clk           : system clock, rising edge
//   rstn          : asynchronous active-low reset
//   request       : per-requester request bits
//   request_valid : qualifies request, sampled only while idle
//   mode_rr       : 0 = fixed priority (lowest index), 1 = round-robin
//   release_i     : completion pulse from the granted master
//                   (named release_i because "release" is a reserved word)
//   grant         : registered one-hot grant
//   grant_index   : registered binary grant index
//   grant_valid   : registered, grant/grant_index meaningful
// Optional starvation guard: define LOCK_RR_ARBITER_STARVE_GUARD_EN.
module lock_rr_arbiter
  import lock_arb_pkg::*;
#(
  parameter  int unsigned REQ_NUM      = 3,
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IW           = idx_width(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [REQ_NUM-1:0] request,
  input  logic               request_valid,
  input  logic               mode_rr,
  input  logic               release_i,
  output logic [REQ_NUM-1:0] grant,
  output logic [IW-1:0]      grant_index,
  output logic               grant_valid
);

  localparam logic [IW-1:0] LAST_IDX = IW'(REQ_NUM - 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               valid_q, valid_d;

  logic [REQ_NUM-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic [REQ_NUM-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               arb;

  assign arb = (state_q == ARB_IDLE) && request_valid && (|request);

  rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .request_i    (request),
    .ptr_i        (ptr_q),
    .mode_rr_i    (mode_rr),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx)
  );

`ifdef LOCK_RR_ARBITER_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]      cnt_q [REQ_NUM];
  logic [CW-1:0]      cnt_d [REQ_NUM];
  logic [REQ_NUM-1:0] starved;
  logic [REQ_NUM-1:0] st_oh;
  logic [IW-1:0]      st_idx;

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      starved[i] = request[i] && (cnt_q[i] == LIMIT);
    end
  end

  // Starved requesters override the normal rule, lowest index first.
  rr_pick #(.REQ_NUM(REQ_NUM)) u_starve (
    .request_i    (starved),
    .ptr_i        ('0),
    .mode_rr_i    (1'b0),
    .winner_oh_o  (st_oh),
    .winner_idx_o (st_idx)
  );

  assign win_oh  = (|starved) ? st_oh  : pick_oh;
  assign win_idx = (|starved) ? st_idx : pick_idx;

  always_comb begin
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (arb) begin
        if (win_oh[i])                          cnt_d[i] = '0;
        else if (request[i] && cnt_q[i] != LIMIT) cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REQ_NUM; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REQ_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign win_oh  = pick_oh;
  assign win_idx = pick_idx;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb) begin
          grant_d = win_oh;
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = ARB_BUSY;
          if (mode_rr) ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (release_i) begin
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_index = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_lock_rr_arbiter.sv
// Testbench for lock_rr_arbiter: a 3-requester instance (STARVE_LIMIT=2) and a
// 5-requester instance. Expected grant indices are queued by the stimulus and
// checked by per-instance monitors when a new grant appears.
module tb_lock_rr_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [2:0] req3;
  logic       rv3, m3, rel3;
  logic [2:0] g3;
  logic [1:0] gi3;
  logic       gv3;

  logic [4:0] req5;
  logic       rv5, m5, rel5;
  logic [4:0] g5;
  logic [2:0] gi5;
  logic       gv5;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned exp3[$];
  int unsigned exp5[$];

  lock_rr_arbiter #(.REQ_NUM(3), .STARVE_LIMIT(2)) dut3 (
    .clk(clk), .rstn(rstn), .request(req3), .request_valid(rv3),
    .mode_rr(m3), .release_i(rel3), .grant(g3), .grant_index(gi3),
    .grant_valid(gv3)
  );

  lock_rr_arbiter #(.REQ_NUM(5)) dut5 (
    .clk(clk), .rstn(rstn), .request(req5), .request_valid(rv5),
    .mode_rr(m5), .release_i(rel5), .grant(g5), .grant_index(gi5),
    .grant_valid(gv5)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: compare each newly appearing grant with the queued expectation,
  // check it stays constant while held, and that outputs are zero when idle.
  logic       pv3 = 1'b0, pv5 = 1'b0;
  logic [4:0] held3, held5;
  logic [7:0] held5w;

  always @(negedge clk) begin
    if (rstn) begin
      if (gv3) begin
        if (!pv3) begin
          chk("grant_expected3", exp3.size() > 0, 1);
          if (exp3.size() > 0) begin
            int unsigned e;
            e = exp3.pop_front();
            chk("grant_index3", gi3, e);
            chk("grant_onehot3", g3, 1 << e);
          end
          held3 = {g3, gi3};
        end else begin
          chk("hold3", {g3, gi3}, held3);
        end
      end else begin
        chk("idle_zero3", {g3, gi3}, 0);
      end
    end
    pv3 = gv3;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (gv5) begin
        if (!pv5) begin
          chk("grant_expected5", exp5.size() > 0, 1);
          if (exp5.size() > 0) begin
            int unsigned e;
            e = exp5.pop_front();
            chk("grant_index5", gi5, e);
            chk("grant_onehot5", g5, 1 << e);
          end
          held5w = {g5, gi5};
        end else begin
          chk("hold5", {g5, gi5}, held5w);
        end
      end else begin
        chk("idle_zero5", {g5, gi5}, 0);
      end
    end
    pv5 = gv5;
  end

  // One locked transaction on dut3: request pulse, hold cycles with noisy
  // inputs (must be ignored), then release.
  task automatic txn3(input logic [2:0] req, input logic m, input int unsigned e,
                      input int unsigned hold);
    exp3.push_back(e);
    @(negedge clk); req3 = req; m3 = m; rv3 = 1'b1;
    @(negedge clk); rv3 = 1'b0;
    chk("latency3", gv3, 1);
    for (int unsigned h = 0; h < hold; h++) begin
      req3 = ~req3; m3 = ~m3; rv3 = 1'b1;
      @(negedge clk);
    end
    rel3 = 1'b1; rv3 = 1'b0;
    @(negedge clk); rel3 = 1'b0;
    chk("release3", gv3, 0);
  endtask

  task automatic txn5(input logic [4:0] req, input int unsigned e);
    exp5.push_back(e);
    @(negedge clk); req5 = req; m5 = 1'b1; rv5 = 1'b1;
    @(negedge clk); rv5 = 1'b0;
    chk("latency5", gv5, 1);
    @(negedge clk); rel5 = 1'b1;
    @(negedge clk); rel5 = 1'b0;
    chk("release5", gv5, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk); rstn = 1'b0; rv3 = 1'b0; rel3 = 1'b0; rv5 = 1'b0; rel5 = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  int unsigned starve_exp [4];

  initial begin
    rstn = 1'b0;
    req3 = 3'b111; rv3 = 1'b1; m3 = 1'b0; rel3 = 1'b0;
    req5 = '0;     rv5 = 1'b0; m5 = 1'b0; rel5 = 1'b0;

    // Reset held with active requests: outputs stay zero.
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", g3, 0);
      chk("rst_index", gi3, 0);
      chk("rst_valid", gv3, 0);
    end
    rv3 = 1'b0;
    rstn = 1'b1;

    // request_valid with no request bits, and release while idle: no grant.
    @(negedge clk); req3 = 3'b000; rv3 = 1'b1;
    @(negedge clk); rv3 = 1'b0;
    chk("empty_req_nogrant", gv3, 0);
    rel3 = 1'b1;
    @(negedge clk); rel3 = 1'b0;
    chk("idle_release", gv3, 0);

    // Fixed priority: 110 -> index 1, held across input changes.
    txn3(3'b110, 1'b0, 1, 3);

    // Back-to-back with request_valid held through release: one-cycle bubble.
    exp3.push_back(1);
    exp3.push_back(1);
    @(negedge clk); req3 = 3'b110; m3 = 1'b0; rv3 = 1'b1;
    @(negedge clk); chk("b2b_first", gv3, 1); rel3 = 1'b1;
    @(negedge clk); rel3 = 1'b0; chk("b2b_bubble", gv3, 0);
    @(negedge clk); rv3 = 1'b0; chk("b2b_second", gv3, 1);
    @(negedge clk); rel3 = 1'b1;
    @(negedge clk); rel3 = 1'b0; chk("b2b_release", gv3, 0);

    // Round-robin over 111: 0,1,2,0 then 1; hold 0 gives one-cycle grants.
    reset_dut();
    txn3(3'b111, 1'b1, 0, 1);
    txn3(3'b111, 1'b1, 1, 0);
    txn3(3'b111, 1'b1, 2, 2);
    txn3(3'b111, 1'b1, 0, 0);
    txn3(3'b111, 1'b1, 1, 0);

    // Fixed grant to index 2 (ptr left at 2), then reset mid-grant.
    exp3.push_back(2);
    @(negedge clk); req3 = 3'b100; m3 = 1'b0; rv3 = 1'b1;
    @(negedge clk); rv3 = 1'b0;
    chk("pre_reset_valid", gv3, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_valid", gv3, 0);
    chk("async_reset_grant", g3, 0);
    @(negedge clk); rstn = 1'b1;
    // ptr must be back at 0.
    txn3(3'b111, 1'b1, 0, 1);

    // Starvation scenario: fixed mode, 101 held.
    reset_dut();
`ifdef LOCK_RR_ARBITER_STARVE_GUARD_EN
    starve_exp = '{0, 0, 2, 0};
`else
    starve_exp = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) txn3(3'b101, 1'b0, starve_exp[i], 1);

    // Five requesters, round-robin over 10001: 0,4,0,4 (ptr wraps 4 -> 0).
    txn5(5'b10001, 0);
    txn5(5'b10001, 4);
    txn5(5'b10001, 0);
    txn5(5'b10001, 4);

    repeat (3) @(negedge clk);
    chk("drain3", exp3.size(), 0);
    chk("drain5", exp5.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lock_rr_arbiter.md
# lock_rr_arbiter

Parametrised request arbiter for the AXI interconnect. It replaces the single-cycle fixed-priority arbiter with a grant that stays locked until the granted master signals completion, for example the end of an AXI burst. Priority is selectable at run time: fixed (lowest index wins) or round-robin. An optional starvation guard can be compiled in. It sits between the per-master request decode and the slave-side address/data multiplexers.

## Interface
Parameters:
- REQ_NUM, 3: number of requesters; must be ≥2; need not be a power of two.
- STARVE_LIMIT, 4: number of lost arbitrations before a requester is promoted; used only with the guard compiled in; must be ≥1.

Ports:
- clk  in  1  single system clock; everything is synchronous to its rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- request  in  REQ_NUM  one bit per requester; bit i set means requester i wants the bus.
- request_valid  in  1  qualifies request; sampled only in IDLE.
- mode_rr  in  1  0 = fixed priority, 1 = round-robin; sampled only at an arbitration.
- release  in  1  single-cycle pulse from the granted master meaning the transaction is done.
- grant  out  REQ_NUM  one-hot grant, registered.
- grant_index  out  $clog2(REQ_NUM)  binary index of the granted requester, registered.
- grant_valid  out  1  grant and grant_index are meaningful, registered.

## Operation
- The FSM has two states: IDLE and BUSY. It resets to IDLE.
- In IDLE:
  - An arbitration happens when request_valid=1 and request≠0.
  - The arbiter picks a winner, registers grant, grant_index and grant_valid=1, and moves to BUSY.
  - If request_valid=1 but request=0, there is no grant and the FSM stays in IDLE.
- In BUSY:
  - grant, grant_index and grant_valid are held constant.
  - Changes on request, request_valid and mode_rr are ignored.
  - When release=1, grant, grant_index and grant_valid all clear at the next edge and the FSM returns to IDLE.
- A release pulse while in IDLE is ignored.
- Fixed mode: the lowest set index wins.
- Round-robin mode:
  - The search starts at pointer ptr and moves upward, wrapping from REQ_NUM-1 to 0.
  - After a round-robin grant to index i, ptr becomes i+1, or 0 when i=REQ_NUM-1.
  - ptr is not updated by fixed-mode grants.
  - ptr resets to 0.
- Winner selection is purely combinational from request, ptr and mode_rr; the selected winner is registered.
- grant is always the one-hot form of grant_index. Both outputs are 0 whenever grant_valid=0.

## Timing
- Reset values: grant=0, grant_index=0, grant_valid=0, ptr=0, state IDLE, all starvation counters 0.
- Reset is asynchronous. Asserting it mid-BUSY drops grant_valid immediately, without waiting for a clock edge.
- Arbitration latency: request_valid sampled at edge N gives grant_valid=1 after edge N+1 (one cycle).
- Release sampled at edge M gives grant_valid=0 after edge M+1.
- The earliest next grant_valid follows edge M+2. There is a mandatory one-cycle bubble between grants.
- A release in the same cycle as the grant first appears is legal; the grant is then one cycle long.

## Configuration
- Macro: LOCK_RR_ARBITER_STARVE_GUARD_EN.
- With the macro defined:
  - Each requester has a wait counter of width $clog2(STARVE_LIMIT+1).
  - At every arbitration, each requester that is asserted but loses increments its counter, saturating at STARVE_LIMIT. The winner's counter clears.
  - If any asserted requester has counter=STARVE_LIMIT, the lowest-index such requester wins in either mode.
  - In round-robin mode, ptr still updates from that winner.
- Without the macro: no counters exist, and selection is the pure fixed or round-robin rule.

## Structure
- Shared package lock_arb_pkg holds:
  - the FSM state typedef (ARB_IDLE, ARB_BUSY);
  - an index-width helper constant function.
- One combinational sub-module, rr_pick: a masked priority picker with inputs request, ptr and mode_rr, and outputs winner one-hot and winner index.
- The top level holds the FSM, ptr, the output registers and the optional counters.

## Test plan
- Reset: hold rstn=0 with request=3'b111 and request_valid=1 → grant=0, grant_index=0, grant_valid=0 throughout.
- Fixed mode: mode_rr=0, request=3'b110, request_valid pulse → one cycle later grant=3'b010, grant_index=1, grant_valid=1. Grant stays held across request changes until release, clears one cycle after release, and the next grant comes no sooner than two cycles after release.
- Round-robin: mode_rr=1, request=3'b111 held, release each transaction → grant_index sequence 0,1,2,0.
- Round-robin with REQ_NUM=5: request=5'b10001 → grants 0,4,0. ptr wraps from 4 to 0 after the grant to index 4.
- Starvation guard, with the macro defined, STARVE_LIMIT=2, mode_rr=0, request=3'b101 held → grants 0,0,2,0. Without the macro → 0,0,0,0.
- Reset mid-BUSY: deassert rstn while grant=3'b100 → grant_valid drops asynchronously. After reset, with mode_rr=1 and request=3'b111, the first grant is index 0 (ptr=0).
